// File: rtl/tmds_dec_if.sv
// TMDS decoder channel bus: one 10-bit deserialized symbol in per clock,
// decoded pixel/control/alignment status out.
//   tmds_data_i   : received symbol, bit 0 = first serial bit
//   px_data_o     : decoded pixel byte
//   px_data_val_o : px_data_o holds a freshly decoded data symbol
//   ctl_0_o/ctl_1_o : control bits from the last control token
//   locked_o      : symbol alignment achieved
//   bitslip_o     : one-cycle request to shift deserializer alignment
// master = symbol source / status sink (deserializer side), slave = decoder.
interface tmds_dec_if;
  logic [9:0] tmds_data_i;
  logic [7:0] px_data_o;
  logic       px_data_val_o;
  logic       ctl_0_o;
  logic       ctl_1_o;
  logic       locked_o;
  logic       bitslip_o;

  modport master (
    output tmds_data_i,
    input  px_data_o, px_data_val_o, ctl_0_o, ctl_1_o, locked_o, bitslip_o
  );

  modport slave (
    input  tmds_data_i,
    output px_data_o, px_data_val_o, ctl_0_o, ctl_1_o, locked_o, bitslip_o
  );
endinterface

// File: rtl/tmds_dec.sv
// Receive-side TMDS decoder for one channel.
// Stage 1 registers the raw symbol plus a control-token match and its code;
// stage 2 registers the decoded pixel / control outputs (2-cycle latency, no
// stalls). An alignment FSM watches the stage-1 token flag and requests
// bitslips until control tokens land on the right boundary.
// Ports:
//   clk_i : symbol clock, one symbol per cycle
//   rst_i : synchronous active-high reset
//   bus   : tmds_dec_if.slave (symbol in, pixel/ctl/lock/bitslip out)
// TMDS_CHANNEL is informational only (channel 0 carries HSYNC/VSYNC).
module tmds_dec #(
  parameter int TMDS_CHANNEL = 0,
  parameter int LOCK_TOKENS  = 8,
  parameter int SEARCH_LEN   = 2048,
  parameter int SLIP_WAIT    = 16
) (
  input logic      clk_i,
  input logic      rst_i,
  tmds_dec_if.slave bus
);

  if (TMDS_CHANNEL < 0 || TMDS_CHANNEL > 2) begin : g_bad_channel
    $error("tmds_dec: TMDS_CHANNEL must be 0, 1 or 2");
  end

  localparam int TW = $clog2(LOCK_TOKENS) + 1;
  localparam int SW = $clog2(SEARCH_LEN) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;

  localparam logic [TW-1:0] TOK_LIM  = TW'(LOCK_TOKENS);
  localparam logic [SW-1:0] SYM_LIM  = SW'(SEARCH_LEN);
  localparam logic [WW-1:0] WAIT_LIM = WW'(SLIP_WAIT);

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT_ST = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  // vld marks stage 1 as holding a real symbol; it is cleared by reset so the
  // zeroed register is neither counted by the FSM nor decoded as a pixel.
  typedef struct packed {
    logic       vld;
    logic       tok;
    logic [1:0] code;
    logic [9:0] sym;
  } s1_t;

  s1_t s1_d, s1_q;

  state_t         state_q;
  logic [TW-1:0]  tok_cnt_q;
  logic [SW-1:0]  sym_cnt_q;
  logic [WW-1:0]  wait_cnt_q;
  logic           locked_q;
  logic           bitslip_q;

  logic [7:0]     px_q;
  logic           px_val_q;
  logic           ctl0_q;
  logic           ctl1_q;

  // ---------------------------------------------------------------- stage 1
  always_comb begin
    s1_d      = '0;
    s1_d.vld  = 1'b1;
    s1_d.sym  = bus.tmds_data_i;
    s1_d.tok  = 1'b1;
    unique case (bus.tmds_data_i)
      10'b1101010100: s1_d.code = 2'b00;
      10'b0010101011: s1_d.code = 2'b01;
      10'b0101010100: s1_d.code = 2'b10;
      10'b1010101011: s1_d.code = 2'b11;
      default:        s1_d.tok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  // TMDS data decode: undo the optional inversion, then undo the XOR/XNOR
  // chain selected by bit 8.
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] px;
    d     = s[9] ? ~s[7:0] : s[7:0];
    px[0] = d[0];
    for (int i = 1; i < 8; i++)
      px[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return px;
  endfunction

  // ---------------------------------------------------------------- stage 2
  // Output gating uses the state before this edge's FSM update, so the symbol
  // that completes a lock is not itself emitted, and the symbol that drops
  // lock is still emitted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_q     <= '0;
      px_val_q <= 1'b0;
      ctl0_q   <= 1'b0;
      ctl1_q   <= 1'b0;
    end else if (s1_q.vld && state_q == LOCKED) begin
      if (s1_q.tok) begin
        px_val_q <= 1'b0;
        ctl0_q   <= s1_q.code[0];
        ctl1_q   <= s1_q.code[1];
      end else begin
        px_val_q <= 1'b1;
        px_q     <= tmds_decode(s1_q.sym);
      end
    end else begin
      px_val_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------- alignment FSM
  // Saturating increments; the FSM leaves the counting state on reaching the
  // limit, so saturation only guards against wrap.
  logic [TW-1:0] tok_inc;
  logic [SW-1:0] sym_inc;
  logic [WW-1:0] wait_inc;
  logic          tok_hit, sym_hit, wait_done;

  always_comb begin
    tok_inc   = (tok_cnt_q  >= TOK_LIM)  ? tok_cnt_q  : tok_cnt_q  + 1'b1;
    sym_inc   = (sym_cnt_q  >= SYM_LIM)  ? sym_cnt_q  : sym_cnt_q  + 1'b1;
    wait_inc  = (wait_cnt_q >= WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;
    tok_hit   = (tok_inc  >= TOK_LIM);
    sym_hit   = (sym_inc  >= SYM_LIM);
    wait_done = (wait_inc >= WAIT_LIM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEARCH;
      tok_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      wait_cnt_q <= '0;
      locked_q   <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (s1_q.vld) begin
            if (s1_q.tok) begin
              sym_cnt_q <= '0;
              if (tok_hit) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                tok_cnt_q <= '0;
              end else begin
                tok_cnt_q <= tok_inc;
              end
            end else begin
              tok_cnt_q <= '0;
              if (sym_hit) begin
                state_q    <= SLIP_WAIT_ST;
                bitslip_q  <= 1'b1;
                sym_cnt_q  <= '0;
                wait_cnt_q <= '0;
              end else begin
                sym_cnt_q <= sym_inc;
              end
            end
          end
        end
        // Deserializer is realigning: symbols in flight are garbage.
        SLIP_WAIT_ST: begin
          if (wait_done) begin
            state_q    <= SEARCH;
            wait_cnt_q <= '0;
            tok_cnt_q  <= '0;
            sym_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_inc;
          end
        end
        LOCKED: begin
          if (s1_q.vld) begin
            if (s1_q.tok) begin
              sym_cnt_q <= '0;
            end else if (sym_hit) begin
              // Lost lock: restart the search without slipping.
              state_q   <= SEARCH;
              locked_q  <= 1'b0;
              sym_cnt_q <= '0;
              tok_cnt_q <= '0;
            end else begin
              sym_cnt_q <= sym_inc;
            end
          end
        end
        default: begin
          state_q   <= SEARCH;
          locked_q  <= 1'b0;
          tok_cnt_q <= '0;
          sym_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.px_data_o     = px_q;
  assign bus.px_data_val_o = px_val_q;
  assign bus.ctl_0_o       = ctl0_q;
  assign bus.ctl_1_o       = ctl1_q;
  assign bus.locked_o      = locked_q;
  assign bus.bitslip_o     = bitslip_q;

endmodule

// File: tb/tb_tmds_dec.sv
// Bench for tmds_dec (LOCK_TOKENS=8, SEARCH_LEN=64, SLIP_WAIT=16): directed
// steps plus randomized segments, checked every cycle against a behavioural
// reference model and at key points against hand-derived constants.
module tb_tmds_dec;
  localparam int LOCK  = 8;
  localparam int SLEN  = 64;
  localparam int SWAIT = 16;

  localparam int M_SEARCH = 0;
  localparam int M_WAIT   = 1;
  localparam int M_LOCK   = 2;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] ROT = 10'h1AA;   // T00 rotated by one bit

  logic clk = 1'b0;
  logic rst;
  tmds_dec_if bus();

  tmds_dec #(
    .TMDS_CHANNEL(0), .LOCK_TOKENS(LOCK), .SEARCH_LEN(SLEN), .SLIP_WAIT(SWAIT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc_n = 0, last_slip = -1000, n_slip = 0, s0;

  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                              10'b0101010100, 10'b1010101011};

  function automatic int tok_idx(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (tok_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] s);
    logic [7:0] d, p;
    d    = s[9] ? (8'hFF - s[7:0]) : s[7:0];
    p[0] = d[0];
    for (int i = 1; i < 8; i++) p[i] = (d[i] == d[i-1]) ? ~s[8] : s[8];
    return p;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    while (tok_idx(s) >= 0) s = 10'($urandom_range(0, 1023));
    return s;
  endfunction

  // ------------------------------------------------------ reference model
  int         m_mode, m_run, m_gap, m_wait, m_t;
  bit         m_have;
  logic [9:0] m_sym;
  logic [7:0] e_px;
  logic       e_val, e_c0, e_c1, e_lock, e_slip;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_SEARCH; m_run = 0; m_gap = 0; m_wait = 0;
      m_have = 0; m_sym = '0;
      e_px = '0; e_val = 0; e_c0 = 0; e_c1 = 0; e_lock = 0; e_slip = 0;
    end else begin
      m_t    = m_have ? tok_idx(m_sym) : -1;
      e_slip = 0;
      if (m_have && m_mode == M_LOCK) begin
        if (m_t >= 0) begin e_val = 0; {e_c1, e_c0} = m_t[1:0]; end
        else begin e_val = 1; e_px = ref_dec(m_sym); end
      end else e_val = 0;
      case (m_mode)
        M_SEARCH: if (m_have) begin
          if (m_t >= 0) begin
            m_run++; m_gap = 0;
            if (m_run == LOCK) begin m_mode = M_LOCK; e_lock = 1; m_run = 0; end
          end else begin
            m_run = 0; m_gap++;
            if (m_gap == SLEN) begin e_slip = 1; m_mode = M_WAIT; m_wait = 0; m_gap = 0; end
          end
        end
        M_WAIT: begin
          m_wait++;
          if (m_wait == SWAIT) begin m_mode = M_SEARCH; m_run = 0; m_gap = 0; end
        end
        default: begin
          if (m_t >= 0) m_gap = 0; else m_gap++;
          if (m_gap == SLEN) begin m_mode = M_SEARCH; e_lock = 0; m_gap = 0; m_run = 0; end
        end
      endcase
      m_sym  = bus.tmds_data_i;
      m_have = 1;
    end
  end

  // ------------------------------------------------------ check helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic [9:0] s);
    bus.tmds_data_i = s;
    @(posedge clk); #1;
    cyc_n++;
    chk("px_data",  32'(bus.px_data_o),     32'(e_px));
    chk("px_val",   32'(bus.px_data_val_o), 32'(e_val));
    chk("ctl_0",    32'(bus.ctl_0_o),       32'(e_c0));
    chk("ctl_1",    32'(bus.ctl_1_o),       32'(e_c1));
    chk("locked",   32'(bus.locked_o),      32'(e_lock));
    chk("bitslip",  32'(bus.bitslip_o),     32'(e_slip));
    if (rst) last_slip = -1000;
    if (bus.bitslip_o === 1'b1) begin
      n_slip++;
      if (last_slip > -1000) chk("slip_gap_ok", 32'(cyc_n - last_slip >= SWAIT + 1), 32'd1);
      last_slip = cyc_n;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.px_data_o, bus.px_data_val_o, bus.ctl_0_o, bus.ctl_1_o,
              bus.locked_o, bus.bitslip_o}, 32'd0);
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1;
    bus.tmds_data_i = '0;
    cyc(10'h0); cyc(10'h0);
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    // Lock acquisition and control decode
    repeat (LOCK) cyc(T00);
    chk("lock_not_yet", 32'(bus.locked_o), 32'd0);
    cyc(T01);
    chk("lock_acquired", 32'(bus.locked_o), 32'd1);
    chk("ctl_00", 32'({bus.ctl_1_o, bus.ctl_0_o}), 32'd0);
    cyc(10'h100);
    chk("ctl_01", 32'({bus.ctl_1_o, bus.ctl_0_o}), 32'd1);

    // Data decode
    cyc(10'h200);
    chk("dec_100", 32'(bus.px_data_o), 32'h00);
    chk("dec_100_val", 32'(bus.px_data_val_o), 32'd1);
    cyc(rnd_data());
    chk("dec_200", 32'(bus.px_data_o), 32'hFF);
    repeat (6) begin
      cyc(rnd_data());
      chk("b2b_val", 32'(bus.px_data_val_o), 32'd1);
    end

    // Reset mid-LOCKED with data streaming
    rst = 1'b1;
    cyc(rnd_data());
    chk_all_zero("reset_mid_lock");
    rst = 1'b0;
    repeat (5) begin
      cyc(rnd_data());
      chk("post_rst_no_val", 32'(bus.px_data_val_o), 32'd0);
    end
    repeat (LOCK + 1) cyc(T00);
    chk("relock", 32'(bus.locked_o), 32'd1);
    cyc(rnd_data()); cyc(rnd_data());
    chk("relock_first_val", 32'(bus.px_data_val_o), 32'd1);

    // Lock loss after SEARCH_LEN data symbols, no bitslip
    s0 = n_slip;
    cyc(T00);
    repeat (SLEN) cyc(rnd_data());
    chk("loss_hold", 32'(bus.locked_o), 32'd1);
    cyc(rnd_data());
    chk("loss_drop", 32'(bus.locked_o), 32'd0);
    chk("loss_last_val", 32'(bus.px_data_val_o), 32'd1);
    cyc(rnd_data());
    chk("loss_val_off", 32'(bus.px_data_val_o), 32'd0);
    chk("loss_no_slip", 32'(n_slip), 32'(s0));

    // Bitslip on misaligned tokens
    rst = 1'b1; cyc(10'h0); rst = 1'b0;
    s0 = n_slip;
    repeat (SLEN) cyc(ROT);
    chk("slip_not_early", 32'(n_slip), 32'(s0));
    cyc(ROT);
    chk("slip_first", 32'(bus.bitslip_o), 32'd1);
    cyc(ROT);
    chk("slip_one_cycle", 32'(bus.bitslip_o), 32'd0);
    repeat (150) cyc(ROT);
    chk("slip_count", 32'(n_slip - s0), 32'd2);
    repeat (40) cyc(T00);
    chk("slip_then_lock", 32'(bus.locked_o), 32'd1);

    // Broken token run
    rst = 1'b1; cyc(10'h0); rst = 1'b0;
    repeat (LOCK - 1) cyc(T00);
    cyc(rnd_data());
    repeat (LOCK - 1) cyc(T00);
    cyc(T00);
    chk("broken_run_pre", 32'(bus.locked_o), 32'd0);
    cyc(T00);
    chk("broken_run_lock", 32'(bus.locked_o), 32'd1);

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rst = 1'b1; cyc(10'($urandom_range(0, 1023))); rst = 1'b0;
      end else if (r < 5) begin
        len = $urandom_range(1, 12);
        repeat (len) cyc(tok_tab[$urandom_range(0, 3)]);
      end else begin
        len = $urandom_range(1, 90);
        repeat (len) cyc(10'($urandom_range(0, 1023)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tmds_dec.md
Name: tmds_dec

Overview:
Receive-side TMDS decoder for one channel. It takes 10-bit deserialized TMDS symbols and recovers 8-bit pixel data plus the two control bits. It also runs a symbol-alignment state machine that requests bitslips from the upstream deserializer until control tokens are found on the correct boundary. One instance per channel sits between the channel deserializer and the video timing recovery logic.

Parameters:
TMDS_CHANNEL, 0, channel index; informational only, does not change logic (channel 0 carries HSYNC/VSYNC on ctl_0/ctl_1).
LOCK_TOKENS, 8, number of consecutive control tokens required to declare lock.
SEARCH_LEN, 2048, number of symbols without any control token before a bitslip (in SEARCH) or loss of lock (in LOCKED).
SLIP_WAIT, 16, number of cycles to ignore input after a bitslip request.

Ports:
clk_i  input  1  symbol clock; one symbol per cycle.
rst_i  input  1  reset, synchronous, active-high.
tmds_data_i  input  10  received symbol; bit 0 is the first serial bit, same bit order as the transmit encoder output.
px_data_o  output  8  decoded pixel data.
px_data_val_o  output  1  px_data_o holds a decoded data symbol.
ctl_0_o  output  1  control bit 0 from the last control token.
ctl_1_o  output  1  control bit 1 from the last control token.
locked_o  output  1  symbol alignment achieved.
bitslip_o  output  1  one-cycle pulse asking the deserializer to shift alignment by one bit.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous, active-high, and takes effect at the next clk_i edge.
- Reset values: all outputs 0. FSM enters SEARCH. All counters and pipeline registers are 0.
- Pipeline, 2 stages:
  - Stage 1 registers the input symbol and a token-match flag with its 2-bit code.
  - Stage 2 registers the decoded outputs.
  - Latency from tmds_data_i to px_data_o/px_data_val_o/ctl outputs is exactly 2 clk_i cycles. No stalls.
- Control tokens, mapping {ctl_1,ctl_0}:
  - 10'b1101010100 -> 00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
- Data decode (any non-token symbol):
  - d = sym[9] ? ~sym[7:0] : sym[7:0].
  - px[0] = d[0].
  - For i = 1..7: px[i] = sym[8] ? d[i]^d[i-1] : d[i]~^d[i-1].
- Output rules:
  - Token while locked: px_data_val_o=0, ctl_0_o/ctl_1_o updated, px_data_o holds its previous value.
  - Data symbol while locked: px_data_val_o=1, px_data_o = decoded value, ctl outputs held.
  - Not locked (SEARCH or SLIP_WAIT): px_data_val_o=0; ctl and px outputs held.
- FSM (evaluated on the stage-1 token flag):
  - SEARCH: tok_cnt increments on each token and clears on any non-token. sym_cnt increments on each non-token and clears on each token.
    - tok_cnt reaching LOCK_TOKENS -> LOCKED, locked_o=1 from the next cycle.
    - Otherwise, sym_cnt reaching SEARCH_LEN -> bitslip_o=1 for one cycle, then SLIP_WAIT.
    - If both conditions occur in the same cycle, lock wins.
  - SLIP_WAIT: wait_cnt counts SLIP_WAIT cycles while input is ignored, then -> SEARCH with tok_cnt and sym_cnt cleared.
  - LOCKED: sym_cnt counts symbols since the last token. sym_cnt reaching SEARCH_LEN -> SEARCH, locked_o=0, counters cleared, no bitslip in that cycle.
- Counter widths: clog2(parameter)+1 bits, saturating compare, no wrap.
- Reset during any state returns to SEARCH. A stale pixel already in the pipeline must not be flagged valid after reset.
- bitslip_o is never asserted in consecutive cycles. There are at least SLIP_WAIT+1 cycles between pulses.

Test Plan:
1. Reset behaviour: assert rst_i mid-LOCKED with data streaming -> on the next cycle all outputs are 0 and locked_o=0; the first valid pixel appears only after a new lock.
2. Lock acquisition: 8 consecutive 10'b1101010100 -> locked_o=1 after the 8th token's stage-1 cycle; ctl_1_o/ctl_0_o=00. Then 10'b0010101011 -> ctl_0_o=1, ctl_1_o=0, two cycles after input.
3. Data decode while locked: input 0x100 -> px_data_o=0x00, px_data_val_o=1, 2 cycles later; input 0x200 -> px_data_o=0xFF. Back-to-back data symbols keep px_data_val_o high every cycle.
4. Bitslip (SEARCH_LEN=64, SLIP_WAIT=16): a stream of tokens rotated by 1 bit -> bitslip_o pulses once after 64 symbols, the next pulse comes no earlier than 17 cycles later; switch to aligned tokens -> lock follows 8 tokens later.
5. Lock loss (SEARCH_LEN=64): locked, then 64 data symbols with no token -> locked_o drops, px_data_val_o=0 from the following cycle, no bitslip pulse.
6. Broken token run: 7 tokens, 1 data symbol, 8 tokens -> lock only after the second run completes.
